// File: rtl/instr_issue.sv
// instr_issue: instruction front end for the datapath controller.
// Buffers 16-bit instructions in a small FIFO, latches one at a time into the
// instruction register, decodes its fields and handshakes with the controller
// through start / waiting. Illegal encodings are dropped with a pulse.
module instr_issue #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [15:0]      instr_in,
  output logic             instr_ready,
  input  logic             waiting,
  input  logic [1:0]       reg_sel,
  output logic             start,
  output logic [2:0]       opcode,
  output logic [1:0]       ALU_op,
  output logic [1:0]       shift_op,
  output logic [2:0]       r_addr,
  output logic [15:0]      sximm8,
  output logic [15:0]      sximm5,
  output logic             instr_done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    BUSY  = 2'b10
  } state_t;

  // Only MOV-class (110 with ALU_op 10/00) and ALU-class (101) words issue.
  function automatic logic is_legal(input logic [15:0] w);
    logic ok;
    case (w[15:13])
      3'b110:  ok = (w[12:11] == 2'b10) || (w[12:11] == 2'b00);
      3'b101:  ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  logic [15:0]      mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic [15:0]      ir_r;
  logic             illegal_r;
  logic [CNT_W-1:0] retired_r;
  state_t           state_r;
  state_t           state_nxt_s;

  logic             full_s;
  logic             empty_s;
  logic             push_s;
  logic             pop_s;
  logic             ir_load_s;
  logic             illegal_nxt_s;
  logic             done_s;
  logic             start_s;
  logic [15:0]      head_s;

  assign full_s  = (count_r == FULL_CNT);
  assign empty_s = (count_r == '0);
  assign push_s  = instr_valid && !full_s;
  assign head_s  = mem_r[rd_ptr_r];

  // FIFO storage, pointers and occupancy; simultaneous push/pop keeps the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= instr_in;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: decides pops, IR loads, illegal drops and completions.
  always_comb begin
    state_nxt_s   = state_r;
    pop_s         = 1'b0;
    ir_load_s     = 1'b0;
    illegal_nxt_s = 1'b0;
    done_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (!empty_s && waiting) begin
          pop_s = 1'b1;
          if (is_legal(head_s)) begin
            ir_load_s   = 1'b1;
            state_nxt_s = START;
          end else begin
            illegal_nxt_s = 1'b1;
            state_nxt_s   = IDLE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        state_nxt_s = BUSY;
      end
      BUSY: begin
        if (waiting) begin
          done_s = 1'b1;
          if (!empty_s) begin
            pop_s = 1'b1;
            if (is_legal(head_s)) begin
              ir_load_s   = 1'b1;
              state_nxt_s = START;
            end else begin
              illegal_nxt_s = 1'b1;
              state_nxt_s   = IDLE;
            end
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = BUSY;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM outputs: start is high for the single START cycle.
  always_comb begin
    start_s = 1'b0;
    case (state_r)
      START:   start_s = 1'b1;
      default: start_s = 1'b0;
    endcase
  end

  // Instruction register; illegal words never overwrite it.
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_r <= 16'h0000;
    end else if (ir_load_s) begin
      ir_r <= head_s;
    end else begin
      ir_r <= ir_r;
    end
  end

  // Illegal pulse is registered so it can never coincide with instr_done.
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_r <= 1'b0;
    end else begin
      illegal_r <= illegal_nxt_s;
    end
  end

  // Retired-instruction counter, wraps naturally at its width.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_r <= '0;
    end else if (done_s) begin
      retired_r <= retired_r + CNT_W'(1);
    end else begin
      retired_r <= retired_r;
    end
  end

  // Register-number mux driven by the controller's reg_sel.
  always_comb begin
    r_addr = 3'b000;
    case (reg_sel)
      2'b10:   r_addr = ir_r[10:8];
      2'b01:   r_addr = ir_r[7:5];
      2'b00:   r_addr = ir_r[2:0];
      default: r_addr = 3'b000;
    endcase
  end

  assign instr_ready = !full_s;
  assign start       = start_s;
  assign instr_done  = done_s;
  assign illegal     = illegal_r;
  assign retired     = retired_r;
  assign opcode      = ir_r[15:13];
  assign ALU_op      = ir_r[12:11];
  assign shift_op    = ir_r[4:3];
  assign sximm8      = {{8{ir_r[7]}}, ir_r[7:0]};
  assign sximm5      = {{11{ir_r[4]}}, ir_r[4:0]};

endmodule

// File: tb/tb_instr_issue.sv
// Directed testbench for instr_issue: reset, decode, stall, back-to-back
// issue, illegal drop, mid-execution reset and retired-counter wrap.
module tb_instr_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr_in = 16'h0000;
  logic        instr_ready;
  logic        waiting = 1'b1;
  logic [1:0]  reg_sel = 2'b00;
  logic        start;
  logic [2:0]  opcode;
  logic [1:0]  ALU_op;
  logic [1:0]  shift_op;
  logic [2:0]  r_addr;
  logic [15:0] sximm8;
  logic [15:0] sximm5;
  logic        instr_done;
  logic        illegal;
  logic [15:0] retired;

  int tests_run = 0;
  int tests_failed = 0;

  instr_issue #(.DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_in(instr_in),
    .instr_ready(instr_ready), .waiting(waiting), .reg_sel(reg_sel),
    .start(start), .opcode(opcode), .ALU_op(ALU_op), .shift_op(shift_op),
    .r_addr(r_addr), .sximm8(sximm8), .sximm5(sximm5),
    .instr_done(instr_done), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; instr_valid = 1'b0; waiting = 1'b1; reg_sel = 2'b00;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    do_reset;
    tests_run++; if (instr_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready: got %b want 1", instr_ready); end
    tests_run++; if (start !== 1'b0) begin tests_failed++; $display("FAIL reset_start: got %b want 0", start); end
    tests_run++; if (instr_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b want 0", instr_done); end
    tests_run++; if (illegal !== 1'b0) begin tests_failed++; $display("FAIL reset_illegal: got %b want 0", illegal); end
    tests_run++; if (retired !== 16'h0000) begin tests_failed++; $display("FAIL reset_retired: got %h want 0000", retired); end
    tests_run++; if (sximm8 !== 16'h0000) begin tests_failed++; $display("FAIL reset_ir: got %h want 0000", sximm8); end
  endtask

  task automatic test_single_issue;
    do_reset;
    instr_in = 16'hD2FB; instr_valid = 1'b1;
    tick;
    instr_valid = 1'b0;
    tests_run++; if (start !== 1'b0) begin tests_failed++; $display("FAIL t1_start_early: got %b want 0", start); end
    tick;
    tests_run++; if (start !== 1'b1) begin tests_failed++; $display("FAIL t1_start: got %b want 1", start); end
    tests_run++; if (opcode !== 3'b110) begin tests_failed++; $display("FAIL t1_opcode: got %b want 110", opcode); end
    tests_run++; if (ALU_op !== 2'b10) begin tests_failed++; $display("FAIL t1_alu: got %b want 10", ALU_op); end
    tests_run++; if (sximm8 !== 16'hFFFB) begin tests_failed++; $display("FAIL t1_sximm8: got %h want FFFB", sximm8); end
    reg_sel = 2'b10; #1;
    tests_run++; if (r_addr !== 3'd2) begin tests_failed++; $display("FAIL t1_rn: got %0d want 2", r_addr); end
    waiting = 1'b0;
    tick;
    tests_run++; if (start !== 1'b0) begin tests_failed++; $display("FAIL t1_start_once: got %b want 0", start); end
    tests_run++; if (instr_done !== 1'b0) begin tests_failed++; $display("FAIL t1_done_early: got %b want 0", instr_done); end
    waiting = 1'b1; #1;
    tests_run++; if (instr_done !== 1'b1) begin tests_failed++; $display("FAIL t1_done: got %b want 1", instr_done); end
    tick;
    tests_run++; if (retired !== 16'd1) begin tests_failed++; $display("FAIL t1_retired: got %0d want 1", retired); end
  endtask

  task automatic test_decode_stall;
    do_reset;
    instr_in = 16'hA16A; instr_valid = 1'b1;
    tick;
    instr_valid = 1'b0;
    tick;
    tests_run++; if (start !== 1'b1) begin tests_failed++; $display("FAIL t2_start: got %b want 1", start); end
    tests_run++; if (opcode !== 3'b101) begin tests_failed++; $display("FAIL t2_opcode: got %b want 101", opcode); end
    tests_run++; if (ALU_op !== 2'b00) begin tests_failed++; $display("FAIL t2_alu: got %b want 00", ALU_op); end
    tests_run++; if (shift_op !== 2'b01) begin tests_failed++; $display("FAIL t2_shift: got %b want 01", shift_op); end
    tests_run++; if (sximm5 !== 16'h000A) begin tests_failed++; $display("FAIL t2_sximm5: got %h want 000A", sximm5); end
    reg_sel = 2'b10; #1;
    tests_run++; if (r_addr !== 3'd1) begin tests_failed++; $display("FAIL t2_rn: got %0d want 1", r_addr); end
    reg_sel = 2'b01; #1;
    tests_run++; if (r_addr !== 3'd3) begin tests_failed++; $display("FAIL t2_rd: got %0d want 3", r_addr); end
    reg_sel = 2'b00; #1;
    tests_run++; if (r_addr !== 3'd2) begin tests_failed++; $display("FAIL t2_rm: got %0d want 2", r_addr); end
    reg_sel = 2'b11; #1;
    tests_run++; if (r_addr !== 3'd0) begin tests_failed++; $display("FAIL t2_rsv: got %0d want 0", r_addr); end
    waiting = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      tests_run++; if (instr_done !== 1'b0 || start !== 1'b0) begin tests_failed++; $display("FAIL t2_stall: done=%b start=%b want 0 0", instr_done, start); end
    end
    waiting = 1'b1; #1;
    tests_run++; if (instr_done !== 1'b1) begin tests_failed++; $display("FAIL t2_done: got %b want 1", instr_done); end
    tick;
    tests_run++; if (instr_done !== 1'b0) begin tests_failed++; $display("FAIL t2_done_once: got %b want 0", instr_done); end
    tests_run++; if (retired !== 16'd1) begin tests_failed++; $display("FAIL t2_retired: got %0d want 1", retired); end
  endtask

  task automatic test_back_to_back;
    do_reset;
    instr_in = 16'hD2FB; instr_valid = 1'b1;
    tick;
    instr_in = 16'hA16A;
    tick;
    tests_run++; if (start !== 1'b1 || opcode !== 3'b110) begin tests_failed++; $display("FAIL t3_first: start=%b op=%b want 1 110", start, opcode); end
    waiting = 1'b0; instr_in = 16'hB800;
    tick;
    tests_run++; if (instr_ready !== 1'b0) begin tests_failed++; $display("FAIL t3_full: got %b want 0", instr_ready); end
    instr_in = 16'h1234;
    tick;
    tests_run++; if (instr_ready !== 1'b0) begin tests_failed++; $display("FAIL t3_full_hold: got %b want 0", instr_ready); end
    waiting = 1'b1; #1;
    tests_run++; if (instr_done !== 1'b1) begin tests_failed++; $display("FAIL t3_done1: got %b want 1", instr_done); end
    tests_run++; if (instr_ready !== 1'b0) begin tests_failed++; $display("FAIL t3_no_bypass: got %b want 0", instr_ready); end
    tick;
    instr_valid = 1'b0;
    tests_run++; if (start !== 1'b1 || instr_done !== 1'b0) begin tests_failed++; $display("FAIL t3_start2: start=%b done=%b want 1 0", start, instr_done); end
    tests_run++; if (opcode !== 3'b101 || ALU_op !== 2'b00) begin tests_failed++; $display("FAIL t3_ir2: op=%b alu=%b want 101 00", opcode, ALU_op); end
    tests_run++; if (retired !== 16'd1) begin tests_failed++; $display("FAIL t3_ret1: got %0d want 1", retired); end
    waiting = 1'b0;
    tick;
    waiting = 1'b1; #1;
    tests_run++; if (instr_done !== 1'b1) begin tests_failed++; $display("FAIL t3_done2: got %b want 1", instr_done); end
    tick;
    tests_run++; if (start !== 1'b1 || ALU_op !== 2'b11) begin tests_failed++; $display("FAIL t3_start3: start=%b alu=%b want 1 11", start, ALU_op); end
    tests_run++; if (retired !== 16'd2) begin tests_failed++; $display("FAIL t3_ret2: got %0d want 2", retired); end
    waiting = 1'b0;
    tick;
    waiting = 1'b1; #1;
    tests_run++; if (instr_done !== 1'b1) begin tests_failed++; $display("FAIL t3_done3: got %b want 1", instr_done); end
    tick;
    tests_run++; if (start !== 1'b0) begin tests_failed++; $display("FAIL t3_idle: got %b want 0", start); end
    tests_run++; if (retired !== 16'd3) begin tests_failed++; $display("FAIL t3_ret3: got %0d want 3", retired); end
    tests_run++; if (instr_ready !== 1'b1) begin tests_failed++; $display("FAIL t3_ready: got %b want 1", instr_ready); end
    tick;
    tick;
    tests_run++; if (illegal !== 1'b0 || start !== 1'b0) begin tests_failed++; $display("FAIL t3_blocked_push: illegal=%b start=%b want 0 0", illegal, start); end
  endtask

  task automatic test_illegal;
    do_reset;
    instr_in = 16'h1234; instr_valid = 1'b1;
    tick;
    instr_valid = 1'b0;
    tests_run++; if (illegal !== 1'b0 || start !== 1'b0) begin tests_failed++; $display("FAIL t4_pop: illegal=%b start=%b want 0 0", illegal, start); end
    tick;
    tests_run++; if (illegal !== 1'b1) begin tests_failed++; $display("FAIL t4_illegal: got %b want 1", illegal); end
    tests_run++; if (start !== 1'b0) begin tests_failed++; $display("FAIL t4_no_start: got %b want 0", start); end
    tick;
    tests_run++; if (illegal !== 1'b0) begin tests_failed++; $display("FAIL t4_illegal_once: got %b want 0", illegal); end
    tests_run++; if (opcode !== 3'b000 || start !== 1'b0) begin tests_failed++; $display("FAIL t4_ir_held: op=%b start=%b want 000 0", opcode, start); end
    tests_run++; if (retired !== 16'd0) begin tests_failed++; $display("FAIL t4_retired: got %0d want 0", retired); end
    instr_in = 16'hD2FB; instr_valid = 1'b1;
    tick;
    instr_valid = 1'b0;
    tick;
    tests_run++; if (start !== 1'b1 || opcode !== 3'b110) begin tests_failed++; $display("FAIL t4_next: start=%b op=%b want 1 110", start, opcode); end
    waiting = 1'b0;
    tick;
    waiting = 1'b1;
    tick;
    tests_run++; if (retired !== 16'd1) begin tests_failed++; $display("FAIL t4_next_ret: got %0d want 1", retired); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    instr_in = 16'hD2FB; instr_valid = 1'b1;
    tick;
    instr_in = 16'hA16A;
    tick;
    instr_valid = 1'b0; waiting = 1'b0;
    tick;
    dut.retired_r = 16'h0005;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tests_run++; if (start !== 1'b0) begin tests_failed++; $display("FAIL t5_start: got %b want 0", start); end
    tests_run++; if (retired !== 16'd0) begin tests_failed++; $display("FAIL t5_retired: got %0d want 0", retired); end
    tests_run++; if (instr_ready !== 1'b1) begin tests_failed++; $display("FAIL t5_ready: got %b want 1", instr_ready); end
    tests_run++; if (opcode !== 3'b000) begin tests_failed++; $display("FAIL t5_ir: got %b want 000", opcode); end
    waiting = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      tests_run++; if (start !== 1'b0 || illegal !== 1'b0) begin tests_failed++; $display("FAIL t5_flushed: start=%b illegal=%b want 0 0", start, illegal); end
    end
  endtask

  task automatic test_wrap;
    do_reset;
    dut.retired_r = 16'hFFFF;
    instr_in = 16'hD2FB; instr_valid = 1'b1;
    tick;
    instr_valid = 1'b0;
    tick;
    waiting = 1'b0;
    tick;
    waiting = 1'b1; #1;
    tests_run++; if (instr_done !== 1'b1) begin tests_failed++; $display("FAIL t6_done: got %b want 1", instr_done); end
    tick;
    tests_run++; if (retired !== 16'h0000) begin tests_failed++; $display("FAIL t6_wrap: got %h want 0000", retired); end
  endtask

  initial begin
    test_reset;
    test_single_issue;
    test_decode_stall;
    test_back_to_back;
    test_illegal;
    test_reset_mid;
    test_wrap;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/instr_issue.md
Name: instr_issue

Overview:
- Instruction front end that sits directly upstream of the lab datapath controller.
- Buffers incoming 16-bit instructions in a small FIFO and latches one at a time into an instruction register (IR).
- Decodes IR fields (opcode, ALU_op, shift_op, register numbers, sign-extended immediates) and drives the controller's start handshake.
- Waits for the controller to return to its waiting state before issuing the next instruction; maps the controller's reg_sel onto a register number for the register file.

Parameters:
- DEPTH, 2: FIFO entries (power of two, at least 2).
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  synchronous reset, active-high.
- instr_valid  input  1  upstream has an instruction on instr_in.
- instr_in  input  16  instruction word.
- instr_ready  output  1  FIFO can accept; equals !full.
- waiting  input  1  controller is in its wait state.
- reg_sel  input  2  controller register select: 10=Rn, 01=Rd, 00=Rm, 11=reserved.
- start  output  1  one-cycle issue pulse to the controller.
- opcode  output  3  IR[15:13].
- ALU_op  output  2  IR[12:11].
- shift_op  output  2  IR[4:3].
- r_addr  output  3  register number selected by reg_sel.
- sximm8  output  16  IR[7:0] sign-extended.
- sximm5  output  16  IR[4:0] sign-extended.
- instr_done  output  1  one-cycle pulse when an issued instruction completes.
- illegal  output  1  one-cycle pulse when a popped instruction is discarded.
- retired  output  CNT_W  count of completed instructions.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FIFO empty, IR=0, FSM=IDLE.
  - start, instr_done, illegal and retired all 0; instr_ready=1 the following cycle.
  - Reset mid-execution discards the IR and all FIFO contents. The controller is reset by its own reset; this block does not track it.
- FIFO:
  - Push when instr_valid && instr_ready.
  - instr_ready = !full, with no bypass: while full, ready stays 0 even in a pop cycle.
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - Pointers wrap modulo DEPTH.
  - Minimum latency: push at edge N, pop into IR at edge N+1, start high in cycle N+1..N+2.
- Legal encodings:
  - opcode 110 with ALU_op 10 or 00.
  - opcode 101 with any ALU_op.
  - All others are illegal.
- FSM IDLE:
  - If FIFO non-empty and waiting=1: pop the head into IR.
  - If the popped word is legal, go to START.
  - If illegal, pulse illegal for 1 cycle, leave IR unchanged, stay in IDLE; the next pop can occur the following cycle.
- FSM START:
  - start=1 for exactly this one cycle, then go to BUSY unconditionally.
  - The controller samples start while in its wait state.
- FSM BUSY:
  - start=0 and IR is held.
  - While waiting=0, stay in BUSY.
  - When waiting=1: pulse instr_done, increment retired (wraps at 2^CNT_W−1 → 0).
  - Then, if FIFO non-empty, pop: a legal word goes to START (back-to-back issue); an illegal word pulses illegal and goes to IDLE.
  - If FIFO empty, go to IDLE.
  - waiting is guaranteed 0 in the first BUSY cycle because the controller has left its wait state.
- Decode outputs:
  - opcode, ALU_op, shift_op, sximm8 and sximm5 are combinational from IR only, stable from START until the next pop.
  - Rn=IR[10:8], Rd=IR[7:5], Rm=IR[2:0].
  - r_addr is a combinational mux on reg_sel; reg_sel=11 gives 3'b000.
- Pulses:
  - instr_done and illegal never assert in the same cycle.
  - start never asserts in the same cycle as instr_done.

Test Plan:
1. Reset, then push 0xD2FB (MOV R2,#-5) with waiting=1 → start pulses exactly once, two cycles after the push. Required outputs: opcode=110, ALU_op=10, sximm8=0xFFFB, and r_addr=2 with reg_sel=10.
2. Push 0xA16A (ADD R3,R1,R2 LSL#1) → opcode=101, ALU_op=00, shift_op=01. r_addr must be 1 / 3 / 2 for reg_sel=10 / 01 / 00. Hold waiting=0 for 4 cycles, then 1 → instr_done pulses once and retired=1.
3. Push 0xD2FB, 0xA16A and 0xB800 back-to-back while the first executes → FIFO full after 2 entries with instr_ready=0. As each completes, the next start follows instr_done by exactly 1 cycle, with no IDLE gap. After the final completion, retired=3.
4. Push 0x1234 (opcode 000) → illegal pulses once, start never asserts, retired unchanged. A following 0xD2FB issues normally.
5. Assert rst during BUSY with 1 entry queued → next cycle: FIFO empty, start=0, retired=0, instr_ready=1. The queued instruction is never issued.
6. Preload retired=0xFFFF (CNT_W=16), then complete one instruction → retired wraps to 0x0000.
